// File: rtl/hash_index_gen.sv
// Buffers CRC32 checksums as {fp, idx1, idx0} bucket entries in a small FIFO.
// The source has no backpressure, so pushes into a full FIFO are dropped and counted.
module hash_index_gen #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned FP_W   = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              checksum,
    input  logic                     crcvalid,
    input  logic                     idx_ready,
    output logic                     idx_valid,
    output logic [ADDR_W-1:0]        idx0,
    output logic [ADDR_W-1:0]        idx1,
    output logic [FP_W-1:0]          fp,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic                     clr_ovf
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2 * ADDR_W + FP_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   fill_q, fill_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic               full, push, pop, drop;
    logic [ADDR_W-1:0]  new_i0, new_i1;
    logic [FP_W-1:0]    new_fp;

    // Buckets must differ and fp==0 marks an empty slot downstream.
    always_comb begin
        new_i0 = checksum[ADDR_W-1:0];
        new_i1 = checksum[2*ADDR_W-1:ADDR_W];
        new_fp = checksum[31:32-FP_W];
        if (new_i1 == new_i0) begin
            new_i1 = new_i0 ^ ADDR_W'(1);
        end
        if (new_fp == '0) begin
            new_fp = FP_W'(1);
        end
    end

    always_comb begin
        full = (fill_q == LVL_W'(DEPTH));
        pop  = (fill_q != '0) && idx_ready;
        push = crcvalid && (!full || pop);
        drop = crcvalid && full && !pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + LVL_W'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - LVL_W'(1);
        end

        // A drop on the same edge as a clear wins and restarts the count at 1.
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = CNT_W'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is cleared too so the head outputs read 0 out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {new_fp, new_i1, new_i0};
        end
    end

    always_comb begin
        idx_valid  = (fill_q != '0);
        idx0       = mem_q[rd_ptr_q][ADDR_W-1:0];
        idx1       = mem_q[rd_ptr_q][2*ADDR_W-1:ADDR_W];
        fp         = mem_q[rd_ptr_q][ENTRY_W-1:2*ADDR_W];
        fill_level = fill_q;
        overflow   = overflow_q;
        drop_cnt   = drop_cnt_q;
    end

endmodule

// File: tb/tb_hash_index_gen.sv
// Directed bench for hash_index_gen: vector table for the index derivation plus
// hand-written sequences for overflow, full push+pop, clear/drop and reset.
module tb_hash_index_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] checksum;
    logic        crcvalid;
    logic        idx_ready;
    logic        idx_valid;
    logic [9:0]  idx0;
    logic [9:0]  idx1;
    logic [7:0]  fp;
    logic [3:0]  fill_level;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_ovf;

    int n_cmp = 0;
    int n_err = 0;

    hash_index_gen #(
        .ADDR_W(10),
        .FP_W  (8),
        .DEPTH (8),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .checksum  (checksum),
        .crcvalid  (crcvalid),
        .idx_ready (idx_ready),
        .idx_valid (idx_valid),
        .idx0      (idx0),
        .idx1      (idx1),
        .fp        (fp),
        .fill_level(fill_level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cs;
        logic [9:0]  e_i0;
        logic [9:0]  e_i1;
        logic [7:0]  e_fp;
    } vec_t;

    vec_t vecs[7];

    // Spec-level reference for the longer sequences.
    function automatic logic [27:0] derive(input logic [31:0] c);
        logic [9:0] a;
        logic [9:0] b;
        logic [7:0] f;
        a = c[9:0];
        b = c[19:10];
        f = c[31:24];
        if (b == a) b = a ^ 10'h001;
        if (f == 8'h00) f = 8'h01;
        return {f, b, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string name, input logic [31:0] cs);
        chk({name, " valid"}, 32'(idx_valid), 32'd1);
        chk({name, " entry"}, {4'h0, fp, idx1, idx0}, {4'h0, derive(cs)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] seq[10];
    logic [31:0] extra;

    initial begin
        reset_n   = 1'b0;
        checksum  = '0;
        crcvalid  = 1'b0;
        idx_ready = 1'b0;
        clr_ovf   = 1'b0;

        vecs[0] = '{32'h12345678, 10'h278, 10'h115, 8'h12};
        vecs[1] = '{32'h00000401, 10'h001, 10'h000, 8'h01};
        vecs[2] = '{32'hFFFFFFFF, 10'h3FF, 10'h3FE, 8'hFF};
        vecs[3] = '{32'h00000000, 10'h000, 10'h001, 8'h01};
        vecs[4] = '{32'hABCDEF01, 10'h301, 10'h37B, 8'hAB};
        vecs[5] = '{32'h00FFFC00, 10'h000, 10'h3FF, 8'h01};
        vecs[6] = '{32'h80000C03, 10'h003, 10'h002, 8'h80};

        #12;
        chk("reset valid", 32'(idx_valid), 0);
        chk("reset head", {4'h0, fp, idx1, idx0}, 0);
        chk("reset fill", 32'(fill_level), 0);
        chk("reset ovf", 32'(overflow), 0);
        chk("reset drop", 32'(drop_cnt), 0);
        step();
        reset_n = 1'b1;
        step();

        // Single push with consumer ready: visible next cycle, gone the one after.
        for (int i = 0; i < 7; i++) begin
            checksum  = vecs[i].cs;
            crcvalid  = 1'b1;
            idx_ready = 1'b1;
            step();
            crcvalid = 1'b0;
            chk($sformatf("vec%0d valid", i), 32'(idx_valid), 1);
            chk($sformatf("vec%0d idx0", i), 32'(idx0), 32'(vecs[i].e_i0));
            chk($sformatf("vec%0d idx1", i), 32'(idx1), 32'(vecs[i].e_i1));
            chk($sformatf("vec%0d fp", i), 32'(fp), 32'(vecs[i].e_fp));
            step();
            chk($sformatf("vec%0d drained", i), 32'(idx_valid), 0);
            chk($sformatf("vec%0d fill", i), 32'(fill_level), 0);
        end

        // Overflow: 10 pushes into a stalled FIFO.
        idx_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seq[k]   = 32'h01020304 * (k + 1) + 32'h00000500;
            checksum = seq[k];
            crcvalid = 1'b1;
            step();
            if (k == 0) chk_head("ovf first held", seq[0]);
        end
        crcvalid = 1'b0;
        chk("ovf fill", 32'(fill_level), 8);
        chk("ovf drop", 32'(drop_cnt), 2);
        chk("ovf flag", 32'(overflow), 1);
        step();
        chk_head("ovf stalled head stable", seq[0]);
        idx_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk_head($sformatf("ovf drain%0d", k), seq[k]);
            step();
        end
        chk("ovf empty", 32'(idx_valid), 0);

        // Full FIFO with push and pop on the same edge.
        idx_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seq[k]   = 32'hC0DE0000 + 32'(k * 32'h00001C07);
            checksum = seq[k];
            crcvalid = 1'b1;
            step();
        end
        extra     = 32'h5A5AA5A5;
        checksum  = extra;
        idx_ready = 1'b1;
        step();
        crcvalid  = 1'b0;
        idx_ready = 1'b0;
        chk("pp fill", 32'(fill_level), 8);
        chk("pp drop", 32'(drop_cnt), 2);
        idx_ready = 1'b1;
        for (int k = 1; k < 8; k++) begin
            chk_head($sformatf("pp drain%0d", k), seq[k]);
            step();
        end
        chk_head("pp last", extra);
        step();
        chk("pp empty", 32'(fill_level), 0);

        // Clear colliding with a drop, then a clean clear.
        idx_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seq[k]   = 32'h3000_0000 + 32'(k * 32'h0000_0811);
            checksum = seq[k];
            crcvalid = 1'b1;
            step();
        end
        checksum = 32'hDEADBEEF;
        clr_ovf  = 1'b1;
        step();
        crcvalid = 1'b0;
        chk("clr+drop ovf", 32'(overflow), 1);
        chk("clr+drop cnt", 32'(drop_cnt), 1);
        step();
        clr_ovf = 1'b0;
        chk("clr ovf", 32'(overflow), 0);
        chk("clr cnt", 32'(drop_cnt), 0);
        chk("clr fill", 32'(fill_level), 8);

        // Reset with 5 entries queued.
        idx_ready = 1'b1;
        step();
        step();
        step();
        idx_ready = 1'b0;
        chk("pre-rst fill", 32'(fill_level), 5);
        chk_head("pre-rst head", seq[3]);
        crcvalid = 1'b1;
        checksum = 32'h11112222;
        step();
        chk("pre-rst ovf", 32'(overflow), 0);
        crcvalid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("rst valid", 32'(idx_valid), 0);
        chk("rst head", {4'h0, fp, idx1, idx0}, 0);
        chk("rst fill", 32'(fill_level), 0);
        step();
        reset_n = 1'b1;
        chk("rst held", 32'(fill_level), 0);
        step();
        checksum = 32'h12345678;
        crcvalid = 1'b1;
        chk("post-rst not early", 32'(idx_valid), 0);
        step();
        crcvalid = 1'b0;
        chk_head("post-rst latency", 32'h12345678);
        chk("post-rst fill", 32'(fill_level), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
